// File: rtl/rv_isa_pkg.sv
// RV32I opcode constants and encoder session state, shared by the
// instruction decoder and encoder.
package rv_isa_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } enc_state_t;

  // True when v is representable as an nbits-wide two's-complement value.
  function automatic logic fits_simm(input logic [31:0] v, input int unsigned nbits);
    logic [31:0] s;
    s = $signed(v) >>> (nbits - 1);
    return (s == 32'h0000_0000) || (s == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO for encoded words: instruction, byte address and error flag.
// Head outputs read as zero while empty.
module enc_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] push_instr,
  input  logic [31:0] push_addr,
  input  logic        push_err,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output logic [31:0] head_instr,
  output logic [31:0] head_addr,
  output logic        head_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_addr  [DEPTH];
  logic        mem_err   [DEPTH];

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        push_ok;
  logic        pop_ok;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_instr[wr_ptr[AW-1:0]] <= push_instr;
      mem_addr[wr_ptr[AW-1:0]]  <= push_addr;
      mem_err[wr_ptr[AW-1:0]]   <= push_err;
    end
  end

  assign head_instr = empty ? 32'h0 : mem_instr[rd_ptr[AW-1:0]];
  assign head_addr  = empty ? 32'h0 : mem_addr[rd_ptr[AW-1:0]];
  assign head_err   = empty ? 1'b0  : mem_err[rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into instruction words and streams them out
// with byte addresses through a small FIFO, one session at a time.
//
// state  | meaning
// IDLE   | waiting for start; no bundles accepted
// ACTIVE | accepting bundles while the FIFO has room
// DRAIN  | last bundle taken; waiting for the FIFO to empty, then done
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic        busy,
  output logic        done,
  output logic [7:0]  err_count
);

  enc_state_t  state, state_d;
  logic [31:0] addr;
  logic        done_d;
  logic        hs;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] enc_word;
  logic        enc_err;

  always_comb begin
    enc_word = NOP;
    enc_err  = 1'b0;
    case (opcode)
      OP: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          enc_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
          enc_err  = |imm[31:5];
        end else begin
          enc_word = {imm[11:0], rs1, funct3, rd, opcode};
          enc_err  = !fits_simm(imm, 12);
        end
      end
      LOAD, JALR: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err  = !fits_simm(imm, 12);
      end
      STORE: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err  = !fits_simm(imm, 12);
      end
      BRANCH: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err  = !fits_simm(imm, 13) || imm[0];
      end
      LUI, AUIPC: begin
        enc_word = {imm[31:12], rd, opcode};
        enc_err  = |imm[11:0];
      end
      JAL: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err  = !fits_simm(imm, 21) || imm[0];
      end
      default: begin
        enc_word = NOP;
        enc_err  = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d  = state;
    in_ready = 1'b0;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_d = ACTIVE;
      end
      ACTIVE: begin
        in_ready = !fifo_full;
        if (in_valid && !fifo_full && in_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign hs   = in_valid && in_ready;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= BASE_ADDR;
      err_count <= 8'd0;
      done      <= 1'b0;
    end else begin
      state <= state_d;
      done  <= done_d;
      if (state == IDLE && start) begin
        addr      <= BASE_ADDR;
        err_count <= 8'd0;
      end else if (hs) begin
        addr <= addr + 32'd4;
        if (enc_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

  enc_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (hs),
    .push_instr (enc_word),
    .push_addr  (addr),
    .push_err   (enc_err),
    .pop        (out_ready),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_instr (out_instr),
    .head_addr  (out_addr),
    .head_err   (out_err)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized checks of instr_encoder; random words are decoded
// back to fields and compared with what was sent.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, in_last;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        out_valid, out_ready, out_err, busy, done;
  logic [31:0] out_instr, out_addr;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rnd_ready = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    int          c;
  } rec_t;
  rec_t got[$];
  logic [63:0] exp_q[$];

  instr_encoder #(.BASE_ADDR(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
    .rs2(rs2), .funct7(funct7), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .out_err(out_err), .busy(busy), .done(done), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rec_t r;
    if (!rst && out_valid && out_ready) begin
      r.instr = out_instr; r.addr = out_addr; r.err = out_err; r.c = cyc;
      got.push_back(r);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] r_d, input logic [2:0] f3,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [6:0] f7,
                      input logic [31:0] im, input logic last);
    bit ok = 0;
    opcode = op; rd = r_d; funct3 = f3; rs1 = r1; rs2 = r2; funct7 = f7; imm = im;
    in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (rnd_ready) out_ready = ($urandom % 4) != 0;
      #0;
      if (in_ready) begin ok = 1; tick(); break; end
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin seen = 1; break; end
      tick();
    end
    chk(tag, {63'd0, seen}, 64'd1);
    if (seen) begin
      chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
      tick();
      chk({tag, "_pulse"}, {63'd0, done}, 64'd0);
    end
  endtask

  // Expected decode view: fields the format does not carry are zeroed.
  function automatic logic [63:0] norm(input logic [6:0] op, input logic [4:0] r_d,
      input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
      input logic [6:0] f7, input logic [31:0] im);
    case (op)
      7'b0110011: return {op, r_d, f3, r1, r2, f7, 32'd0};
      7'b0010011: if (f3 == 3'b001 || f3 == 3'b101) return {op, r_d, f3, r1, 5'd0, f7, im};
                  else return {op, r_d, f3, r1, 5'd0, 7'd0, im};
      7'b0000011, 7'b1100111: return {op, r_d, f3, r1, 5'd0, 7'd0, im};
      7'b0100011, 7'b1100011: return {op, 5'd0, f3, r1, r2, 7'd0, im};
      default: return {op, r_d, 3'd0, 5'd0, 5'd0, 7'd0, im};
    endcase
  endfunction

  function automatic logic [63:0] decode(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    op = w[6:0]; f3 = w[14:12];
    case (op)
      7'b0110011: return norm(op, w[11:7], f3, w[19:15], w[24:20], w[31:25], 32'd0);
      7'b0010011: if (f3 == 3'b001 || f3 == 3'b101)
                    return norm(op, w[11:7], f3, w[19:15], 5'd0, w[31:25], {27'd0, w[24:20]});
                  else return norm(op, w[11:7], f3, w[19:15], 5'd0, 7'd0, {{20{w[31]}}, w[31:20]});
      7'b0000011, 7'b1100111:
        return norm(op, w[11:7], f3, w[19:15], 5'd0, 7'd0, {{20{w[31]}}, w[31:20]});
      7'b0100011:
        return norm(op, 5'd0, f3, w[19:15], w[24:20], 7'd0, {{20{w[31]}}, w[31:25], w[11:7]});
      7'b1100011:
        return norm(op, 5'd0, f3, w[19:15], w[24:20], 7'd0,
                    {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0});
      7'b0110111, 7'b0010111:
        return norm(op, w[11:7], 3'd0, 5'd0, 5'd0, 7'd0, {w[31:12], 12'd0});
      7'b1101111:
        return norm(op, w[11:7], 3'd0, 5'd0, 5'd0, 7'd0,
                    {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0});
      default: return 64'hDEAD_DEAD_DEAD_DEAD;
    endcase
  endfunction

  initial begin
    logic [6:0]  r_op, r_f7;
    logic [4:0]  r_rd, r_rs1, r_rs2;
    logic [2:0]  r_f3;
    logic [31:0] r_imm;
    int n;

    rst = 1; start = 0; in_valid = 0; in_last = 0; out_ready = 0;
    opcode = 0; rd = 0; funct3 = 0; rs1 = 0; rs2 = 0; funct7 = 0; imm = 0;
    tick(); tick();
    rst = 0;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
    chk("rst_out_addr", {32'd0, out_addr}, 64'd0);
    chk("rst_out_err", {63'd0, out_err}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err_count", {56'd0, err_count}, 64'd0);

    // single addi
    got.delete(); out_ready = 1;
    do_start();
    chk("active_in_ready", {63'd0, in_ready}, 64'd1);
    send(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 1'b1);
    chk("addi_latency_valid", {63'd0, out_valid}, 64'd1);
    wait_done("addi_done");
    chk("addi_count", 64'(got.size()), 64'd1);
    if (got.size() >= 1) begin
      chk("addi_word", {32'd0, got[0].instr}, 64'h00500093);
      chk("addi_addr", {32'd0, got[0].addr}, 64'd0);
      chk("addi_err", {63'd0, got[0].err}, 64'd0);
    end

    // add / sub back to back
    got.delete();
    do_start();
    send(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'd0, 1'b0);
    send(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'd0, 1'b1);
    wait_done("addsub_done");
    chk("addsub_count", 64'(got.size()), 64'd2);
    if (got.size() >= 2) begin
      chk("add_word", {32'd0, got[0].instr}, 64'h002081B3);
      chk("add_addr", {32'd0, got[0].addr}, 64'h0);
      chk("sub_word", {32'd0, got[1].instr}, 64'h402081B3);
      chk("sub_addr", {32'd0, got[1].addr}, 64'h4);
      chk("addsub_consecutive", 64'(got[1].c - got[0].c), 64'd1);
    end

    // formats and error cases
    got.delete();
    do_start();
    send(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd8, 1'b0);
    send(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 1'b0);
    send(7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000, 1'b0);
    send(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 1'b0);
    send(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd3, 1'b0);
    send(7'h7F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0, 1'b1);
    wait_done("fmt_done");
    chk("fmt_err_count", {56'd0, err_count}, 64'd3);
    chk("fmt_count", 64'(got.size()), 64'd6);
    if (got.size() >= 6) begin
      chk("beq_word", {32'd0, got[0].instr}, 64'h00208463);
      chk("jal_word", {32'd0, got[1].instr}, 64'h001000EF);
      chk("lui_word", {32'd0, got[2].instr}, 64'h123452B7);
      chk("ok_errs", {61'd0, got[0].err, got[1].err, got[2].err}, 64'd0);
      chk("addi_range_err", {63'd0, got[3].err}, 64'd1);
      chk("beq_odd_err", {63'd0, got[4].err}, 64'd1);
      chk("unknown_word", {32'd0, got[5].instr}, 64'h00000013);
      chk("unknown_err", {63'd0, got[5].err}, 64'd1);
      chk("unknown_addr", {32'd0, got[5].addr}, 64'd20);
    end

    // backpressure
    got.delete(); out_ready = 0;
    do_start();
    send(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1, 1'b0);
    send(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2, 1'b0);
    opcode = 7'h13; rd = 5'd1; funct3 = 0; rs1 = 0; imm = 32'd3; in_last = 1; in_valid = 1;
    tick(); tick(); tick();
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_head_word", {32'd0, out_instr}, 64'h00100093);
    chk("bp_head_addr", {32'd0, out_addr}, 64'd0);
    out_ready = 1;
    send(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3, 1'b1);
    wait_done("bp_done");
    chk("bp_count", 64'(got.size()), 64'd3);
    if (got.size() >= 3) begin
      chk("bp_order", {got[0].instr[31:20], got[1].instr[31:20], got[2].instr[31:20], 28'd0},
          {12'd1, 12'd2, 12'd3, 28'd0});
      chk("bp_third_addr", {32'd0, got[2].addr}, 64'd8);
    end

    // reset mid-session
    got.delete(); out_ready = 0;
    do_start();
    send(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4096, 1'b0);
    chk("mid_err_count", {56'd0, err_count}, 64'd1);
    chk("mid_busy", {63'd0, busy}, 64'd1);
    rst = 1; tick(); rst = 0;
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_err_count", {56'd0, err_count}, 64'd0);
    out_ready = 1;
    do_start();
    send(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd7, 1'b1);
    wait_done("restart_done");
    chk("restart_count", 64'(got.size()), 64'd1);
    if (got.size() >= 1) begin
      chk("restart_addr", {32'd0, got[0].addr}, 64'd0);
      chk("restart_word", {32'd0, got[0].instr}, 64'h00700093);
    end

    // random legal round trip
    got.delete(); exp_q.delete(); n = 40;
    do_start();
    rnd_ready = 1;
    for (int i = 0; i < n; i++) begin
      r_rd = 5'($urandom); r_rs1 = 5'($urandom); r_rs2 = 5'($urandom);
      r_f3 = 3'($urandom); r_f7 = 7'($urandom);
      case ($urandom_range(0, 8))
        0: begin r_op = 7'b0110011; r_imm = 32'd0; end
        1: begin r_op = 7'b0010011; r_f3 = ($urandom % 2) ? 3'b001 : 3'b101;
                 r_imm = 32'($urandom_range(0, 31)); end
        2: begin r_op = 7'b0010011; if (r_f3 == 3'b001 || r_f3 == 3'b101) r_f3 = 3'b000;
                 r_imm = 32'($urandom_range(0, 4095)) - 32'd2048; end
        3: begin r_op = 7'b0000011; r_imm = 32'($urandom_range(0, 4095)) - 32'd2048; end
        4: begin r_op = 7'b1100111; r_imm = 32'($urandom_range(0, 4095)) - 32'd2048; end
        5: begin r_op = 7'b0100011; r_imm = 32'($urandom_range(0, 4095)) - 32'd2048; end
        6: begin r_op = 7'b1100011; r_imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1; end
        7: begin r_op = ($urandom % 2) ? 7'b0110111 : 7'b0010111;
                 r_imm = $urandom & 32'hFFFF_F000; end
        default: begin r_op = 7'b1101111;
                 r_imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1; end
      endcase
      exp_q.push_back(norm(r_op, r_rd, r_f3, r_rs1, r_rs2, r_f7, r_imm));
      send(r_op, r_rd, r_f3, r_rs1, r_rs2, r_f7, r_imm, i == n - 1);
    end
    rnd_ready = 0; out_ready = 1;
    wait_done("rand_done");
    chk("rand_count", 64'(got.size()), 64'(n));
    chk("rand_err_count", {56'd0, err_count}, 64'd0);
    for (int i = 0; i < n && i < got.size(); i++) begin
      chk($sformatf("rand_fields_%0d", i), decode(got[i].instr), exp_q[i]);
      chk($sformatf("rand_addr_%0d", i), {32'd0, got[i].addr}, 64'(4 * i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decoder: accepts decoded RV32I fields (opcode, rd, rs1, rs2, funct3, funct7, imm) and packs them into 32-bit instruction words.
- Words are streamed out with a word address for instruction-memory preload and for self-checking benches (encode then decode must round-trip).
- A valid/ready input, a small output FIFO and a session FSM (start/last/done) make it a sequential block.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word in a session.
- FIFO_DEPTH, 2, output FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  pulse: begin session, load address counter with BASE_ADDR
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_last  in  1  final bundle of the session
- opcode  in  7  major opcode
- rd  in  5  destination register
- funct3  in  3  funct3
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct7  in  7  funct7; upper bits for shift-immediates
- imm  in  32  sign-extended immediate, same meaning as the decoder output
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_instr  out  32  encoded word
- out_addr  out  32  byte address of out_instr
- out_err  out  1  head word had a range or opcode error
- busy  out  1  session active or draining
- done  out  1  one-cycle pulse when the session completes
- err_count  out  8  errors in the current session, saturating at 255

Behaviour:
- Reset values:
  - FSM in IDLE; FIFO empty; address equals BASE_ADDR.
  - out_valid=0, out_instr=0, out_addr=0, out_err=0.
  - in_ready=0, busy=0, done=0, err_count=0.
- FSM IDLE -> ACTIVE on start:
  - Address is set to BASE_ADDR and err_count is cleared.
  - start in ACTIVE or DRAIN is ignored.
- ACTIVE:
  - in_ready = FIFO not full (an entry popped in the same cycle does not count).
  - Handshake occurs when in_valid and in_ready are both high.
  - On handshake the encoded word, address and error are pushed, and address advances by 4 with 32-bit wrap.
  - Handshake with in_last goes to DRAIN.
- DRAIN:
  - in_ready=0.
  - When the FIFO becomes empty, done pulses for one cycle in the next cycle and the FSM goes to IDLE.
- Latency: accepted bundle appears at out_* the next cycle if the FIFO was empty. Throughput is one word per cycle while out_ready=1.
- FIFO:
  - Head is held stable while out_valid=1 and out_ready=0.
  - Simultaneous push and pop when full is not allowed, since in_ready is low.
  - Simultaneous push and pop when non-full keeps the occupancy unchanged.
- Encoding by opcode (fields not used by the format are ignored):
  - R (0110011): funct7, rs2, rs1, funct3, rd, opcode.
  - OP-IMM (0010011), funct3 001 or 101: funct7, imm[4:0], rs1, funct3, rd, opcode. Error if imm[31:5] is not zero.
  - OP-IMM other funct3, LOAD (0000011), JALR (1100111): imm[11:0], rs1, funct3, rd, opcode. Error if imm is outside [-2048, 2047].
  - STORE (0100011): imm[11:5], rs2, rs1, funct3, imm[4:0], opcode. Same range rule as OP-IMM.
  - BRANCH (1100011): imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode. Error if imm is outside [-4096, 4094] or imm[0]=1.
  - LUI (0110111), AUIPC (0010111): imm[31:12], rd, opcode. Error if imm[11:0] is not zero.
  - JAL (1101111): imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode. Error if imm is outside [-2^20, 2^20-2] or imm[0]=1.
- Range error: the word is emitted from truncated imm bits, with err=1.
- Unknown opcode: the word is 32'h0000_0013 (NOP), with err=1.
- err_count increments on each handshake whose bundle has an error, saturating at 255.
- rst mid-session: everything returns to reset values at the next edge and FIFO contents are discarded.

Decomposition:
- Package rv_isa_pkg:
  - Opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC) and the NOP constant.
  - enum enc_state_t {IDLE, ACTIVE, DRAIN}.
- Shared by the decoder and the encoder.
- One sub-module: enc_fifo (parameterised sync FIFO: data, addr, err; full/empty).
- Encoding and range check stay combinational in the top module.

Test Plan:
- start, then a single bundle with in_last, addi x1,x0,5 (op 0010011, rd=1, f3=0, imm=5) -> out_instr=0x00500093, out_addr=0x0, err=0; done pulses after the pop.
- add x3,x1,x2 then sub (funct7=0x20) back-to-back, out_ready=1 -> 0x002081B3 at addr 0x0 and 0x402081B3 at addr 0x4, on consecutive cycles.
- beq x1,x2,+8 -> 0x00208463. jal x1,+2048 -> 0x001000EF. lui x5 with imm=0x12345000 -> 0x123452B7.
- Error cases:
  - addi with imm=2048 -> err=1.
  - beq with imm=3 -> err=1.
  - opcode 0x7F -> word 0x00000013 with err=1.
  - After these, err_count=3.
- out_ready held 0, 3 bundles offered -> 2 accepted, in_ready=0. Release out_ready -> third bundle accepted at addr 0x8, with order preserved.
- rst asserted with 1 entry queued in ACTIVE -> next cycle out_valid=0, busy=0, err_count=0. A new start restarts at BASE_ADDR.
- Round-trip: random legal bundles encoded and then decoded -> fields and imm match exactly.
